phase_sequencer: RTL and testbench
==================================

# phase_sequencer

Multicycle phase sequencer for the KAPPA3 light core: it generates the one-hot `cstate` (IF/DE/EX/WB) consumed by the combinational controller and adds run/step/stop control. It also provides memory wait-state stalling, a PC breakpoint and a retired-instruction counter. It replaces the free-running phase generator and sits between the front-panel/host control inputs, the memory, and the controller/datapath.

## Interface
- No parameters; widths fixed (32-bit PC, 4-bit one-hot phase).
- `clock`  in  1  system clock; all state changes on its rising edge
- `reset`  in  1  synchronous, active-low reset
- `run`  in  1  level; start continuous execution from STOP
- `step`  in  1  single-cycle pulse; execute exactly one instruction from STOP
- `stop`  in  1  single-cycle pulse; halt after current instruction's WB
- `mem_ack`  in  1  memory completion for the current IF fetch / WB access
- `wb_mem`  in  1  current instruction accesses memory in WB (controller `mem_read | mem_write`)
- `pc`  in  32  current PC register value
- `bp_addr`  in  32  breakpoint address
- `bp_en`  in  1  breakpoint enable
- `cstate`  out  4  phase: 0001 IF, 0010 DE, 0100 EX, 1000 WB, 0000 STOP
- `phase_end`  out  1  last cycle of current phase; top level ANDs every datapath load enable (pc_ld, ir_ld, a_ld, b_ld, c_ld, rd_ld, mem_write) with it
- `running`  out  1  1 whenever cstate ≠ STOP
- `bp_hit`  out  1  sticky; set when execution halted by breakpoint
- `instret`  out  32  retired-instruction count

## Operation
- States: STOP, IF, DE, EX, WB. Reset → STOP.
- STOP: `phase_end`=0. Priority stop > step > run. `stop` → stay. `step` → IF, mode=STEP. `run`=1 → IF, mode=RUN. Leaving STOP clears `bp_hit`.
- IF: `phase_end` = `mem_ack`. Advance to DE when `mem_ack`=1, else hold.
- DE, EX: single cycle each, `phase_end`=1.
- WB: `phase_end` = `wb_mem ? mem_ack : 1`. On completion `instret` += 1 (wraps 0xFFFFFFFF→0). Next state:
  - mode=STEP or `stop_pending` → STOP.
  - `run`=0 → STOP.
  - breakpoint match (next PC == `bp_addr`, `bp_en`=1) → STOP, set `bp_hit`.
  - otherwise → IF.
- Breakpoint match uses `pc` sampled on the cycle after WB completion. This is realised as an IF-entry check: when entering IF from WB with a match, the sequencer goes to STOP instead and no fetch occurs. The first IF after leaving STOP never checks the breakpoint, so resume/step proceeds past it.
- `stop` pulse in any non-STOP state sets `stop_pending`. `stop_pending` is cleared on entry to STOP. A `stop` in the same cycle as WB completion is honoured in that cycle.
- `run`/`step` ignored outside STOP.
- `reset` low in any state: next cycle STOP, mode, `stop_pending`, `bp_hit` and `instret` cleared. A partially complete instruction is abandoned with no retire count.

## Timing
- Reset values: `cstate`=0000, `phase_end`=0, `running`=0, `bp_hit`=0, `instret`=0.
- All outputs registered except `phase_end`, which is combinational from state, `mem_ack` and `wb_mem`.
- Zero-wait instruction: 4 cycles (IF, DE, EX, WB). Each `mem_ack`-low cycle in IF, or in WB with `wb_mem`=1, adds one cycle.
- STOP → IF: one cycle after `run`/`step` is sampled.
- `instret` updates on the edge ending WB and is visible the next cycle.

## Configuration
- `PHASE_SEQ_BREAKPOINT_EN` defined: breakpoint logic and `bp_hit` behave as above.
- Undefined: `bp_addr`/`bp_en` ignored, `bp_hit` tied 0, no comparator synthesised. Ports are retained.

## Structure
- Shared package `kappa3_pkg`: phase constants PH_STOP/PH_IF/PH_DE/PH_EX/PH_WB (4-bit one-hot) and the sequencer state/mode enums. The controller imports the same phase constants.
- One sub-module: `phase_bp_match` (32-bit compare + first-IF suppression flag), instantiated only under `PHASE_SEQ_BREAKPOINT_EN`.

## Test plan
- Reset low 2 cycles, then high with `run`=1, `mem_ack`=1, `wb_mem`=0 → cstate 0001,0010,0100,1000 repeating; `instret`=3 after 12 cycles.
- `step` pulse from STOP, `mem_ack`=1 → exactly IF,DE,EX,WB then 0000; `instret`=1; `running` falls after WB.
- `mem_ack` low 3 cycles in IF, and low 2 cycles in WB with `wb_mem`=1 → instruction takes 9 cycles; `phase_end` high only on the final IF and WB cycles.
- `bp_addr`=0x40, `bp_en`=1, PC stepping by 4 from 0x38 under `run` → halts after WB of 0x3C with `bp_hit`=1. A following `step` executes 0x40 without re-halting.
- `stop` pulse during DE → current instruction completes WB, then STOP; `stop` and `step` together in STOP → stays STOP.
- Reset asserted during EX → next cycle `cstate`=0000 and `instret`=0; instruction not counted.

Source files
------------

// File: rtl/kappa3_pkg.sv
// kappa3_pkg
// Shared definitions for the KAPPA3 light core control path.
// PH_* are the one-hot phase codes driven on cstate; the controller decodes
// the same constants. seq_state_t reuses them as its encoding so the state
// register can be presented on cstate directly.
package kappa3_pkg;

    localparam logic [3:0] PH_STOP = 4'b0000;
    localparam logic [3:0] PH_IF   = 4'b0001;
    localparam logic [3:0] PH_DE   = 4'b0010;
    localparam logic [3:0] PH_EX   = 4'b0100;
    localparam logic [3:0] PH_WB   = 4'b1000;

    typedef enum logic [3:0] {
        SEQ_STOP = PH_STOP,
        SEQ_IF   = PH_IF,
        SEQ_DE   = PH_DE,
        SEQ_EX   = PH_EX,
        SEQ_WB   = PH_WB
    } seq_state_t;

    typedef enum logic {
        MODE_RUN  = 1'b0,
        MODE_STEP = 1'b1
    } seq_mode_t;

endpackage

// File: rtl/phase_bp_match.sv
// phase_bp_match
// PC breakpoint comparator for the phase sequencer.
// The PC register loads on the edge that ends WB, so the new PC is only
// visible in the following cycle. i_arm marks a WB->IF hand-off; r_check
// holds it for exactly that first IF cycle, which is when the compare is
// meaningful. An IF entered from STOP is never armed, so resuming or
// stepping from a breakpoint address proceeds past it.
// Ports:
//   clock      system clock
//   reset      synchronous active-low reset
//   i_arm      WB completing with IF as next phase
//   i_pc       current PC register value
//   i_bp_addr  breakpoint address
//   i_bp_en    breakpoint enable
//   o_match    breakpoint hit in the first IF cycle after WB
module phase_bp_match (
    input  logic        clock,
    input  logic        reset,
    input  logic        i_arm,
    input  logic [31:0] i_pc,
    input  logic [31:0] i_bp_addr,
    input  logic        i_bp_en,
    output logic        o_match
);

    logic r_check;

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_check <= 1'b0;
        end else begin
            r_check <= i_arm;
        end
    end

    assign o_match = r_check & i_bp_en & (i_pc == i_bp_addr);

endmodule

// File: rtl/phase_sequencer.sv
// phase_sequencer
// Multicycle phase sequencer for the KAPPA3 light core: one-hot IF/DE/EX/WB
// phase generation with run/step/stop control, memory wait-state stalling,
// optional PC breakpoint and a retired-instruction counter.
// Optional feature macro: PHASE_SEQ_BREAKPOINT_EN (breakpoint comparator and
// bp_hit; when undefined bp_addr/bp_en are ignored and bp_hit is 0).
// Ports:
//   clock, reset          system clock, synchronous active-low reset
//   run, step, stop       front-panel/host control (level, pulse, pulse)
//   mem_ack               memory completion for IF fetch / WB access
//   wb_mem                current instruction accesses memory in WB
//   pc, bp_addr, bp_en    PC value and breakpoint setup
//   cstate                one-hot phase, 0000 when stopped
//   phase_end             last cycle of phase; gates all datapath loads
//   running               cstate != STOP
//   bp_hit                sticky breakpoint-halt flag
//   instret               retired-instruction count
//
// state | meaning
// ------+---------------------------------------------------------------
// STOP  | halted; waits for step (single instruction) or run (continuous)
// IF    | instruction fetch; stalls until mem_ack; breakpoint check on
//       | the first cycle after WB
// DE    | decode, one cycle
// EX    | execute, one cycle
// WB    | write-back; stalls on mem_ack when wb_mem; retires instruction
module phase_sequencer
    import kappa3_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        run,
    input  logic        step,
    input  logic        stop,
    input  logic        mem_ack,
    input  logic        wb_mem,
    input  logic [31:0] pc,
    input  logic [31:0] bp_addr,
    input  logic        bp_en,
    output logic [3:0]  cstate,
    output logic        phase_end,
    output logic        running,
    output logic        bp_hit,
    output logic [31:0] instret
);

    seq_state_t  r_state;
    seq_state_t  w_state_next;
    seq_mode_t   r_mode;
    seq_mode_t   w_mode_next;
    logic        r_stop_pending;
    logic [31:0] r_instret;
    logic        w_phase_end;
    logic        w_bp_stop;
    logic        w_bp_match;
    logic        w_retire;

    always_comb begin
        w_state_next = r_state;
        w_mode_next  = r_mode;
        w_phase_end  = 1'b0;
        w_bp_stop    = 1'b0;
        case (r_state)
            SEQ_STOP: begin
                if (stop) begin
                    w_state_next = SEQ_STOP;
                end else if (step) begin
                    w_state_next = SEQ_IF;
                    w_mode_next  = MODE_STEP;
                end else if (run) begin
                    w_state_next = SEQ_IF;
                    w_mode_next  = MODE_RUN;
                end
            end
            SEQ_IF: begin
                // A breakpoint hit abandons the fetch: phase_end stays low
                // so neither IR nor PC loads.
                if (w_bp_match) begin
                    w_state_next = SEQ_STOP;
                    w_bp_stop    = 1'b1;
                end else begin
                    w_phase_end = mem_ack;
                    if (mem_ack) begin
                        w_state_next = SEQ_DE;
                    end
                end
            end
            SEQ_DE: begin
                w_phase_end  = 1'b1;
                w_state_next = SEQ_EX;
            end
            SEQ_EX: begin
                w_phase_end  = 1'b1;
                w_state_next = SEQ_WB;
            end
            SEQ_WB: begin
                w_phase_end = wb_mem ? mem_ack : 1'b1;
                if (w_phase_end) begin
                    // stop in the completing cycle counts as pending
                    if ((r_mode == MODE_STEP) || r_stop_pending || stop || !run) begin
                        w_state_next = SEQ_STOP;
                    end else begin
                        w_state_next = SEQ_IF;
                    end
                end
            end
            default: begin
                w_state_next = SEQ_STOP;
            end
        endcase
    end

    assign w_retire = (r_state == SEQ_WB) & w_phase_end;

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state        <= SEQ_STOP;
            r_mode         <= MODE_RUN;
            r_stop_pending <= 1'b0;
            r_instret      <= 32'd0;
        end else begin
            r_state <= w_state_next;
            r_mode  <= w_mode_next;
            if (w_state_next == SEQ_STOP) begin
                r_stop_pending <= 1'b0;
            end else if (stop && (r_state != SEQ_STOP)) begin
                r_stop_pending <= 1'b1;
            end
            if (w_retire) begin
                r_instret <= r_instret + 32'd1;
            end
        end
    end

`ifdef PHASE_SEQ_BREAKPOINT_EN
    logic w_arm;
    logic r_bp_hit;

    assign w_arm = w_retire & (w_state_next == SEQ_IF);

    phase_bp_match u_bp_match (
        .clock     (clock),
        .reset     (reset),
        .i_arm     (w_arm),
        .i_pc      (pc),
        .i_bp_addr (bp_addr),
        .i_bp_en   (bp_en),
        .o_match   (w_bp_match)
    );

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_bp_hit <= 1'b0;
        end else if ((r_state == SEQ_STOP) && (w_state_next != SEQ_STOP)) begin
            r_bp_hit <= 1'b0;
        end else if (w_bp_stop) begin
            r_bp_hit <= 1'b1;
        end
    end

    assign bp_hit = r_bp_hit;
`else
    logic w_unused_bp;

    // ports kept for a uniform top-level interface
    assign w_unused_bp = ^{pc, bp_addr, bp_en, w_bp_stop};
    assign w_bp_match  = 1'b0;
    assign bp_hit      = 1'b0;
`endif

    assign cstate    = r_state;
    assign running   = (r_state != SEQ_STOP);
    assign phase_end = w_phase_end;
    assign instret   = r_instret;

endmodule

// File: tb/tb_phase_sequencer.sv
module tb_phase_sequencer;
    import kappa3_pkg::*;

    logic        clock = 1'b0;
    logic        reset, run, step, stop, mem_ack, wb_mem, bp_en;
    logic [31:0] pc, bp_addr;
    logic [3:0]  cstate;
    logic        phase_end, running, bp_hit;
    logic [31:0] instret;

    phase_sequencer dut (
        .clock     (clock),
        .reset     (reset),
        .run       (run),
        .step      (step),
        .stop      (stop),
        .mem_ack   (mem_ack),
        .wb_mem    (wb_mem),
        .pc        (pc),
        .bp_addr   (bp_addr),
        .bp_en     (bp_en),
        .cstate    (cstate),
        .phase_end (phase_end),
        .running   (running),
        .bp_hit    (bp_hit),
        .instret   (instret)
    );

    always #5 clock = ~clock;

    typedef struct {
        string       tag;
        logic [3:0]  cs;
        logic        pe;
        logic        bh;
        logic [31:0] ir;
    } exp_t;

    exp_t        sb[$];
    exp_t        e;
    int          total = 0;
    int          bad   = 0;
    logic [31:0] m_ir;
    logic        m_bh;

    task automatic cmp(input string tag, input string what,
                       input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s.%s: got %h want %h", tag, what, act, req);
        end
    endtask

    // monitor: one expected record per cycle, sampled mid-cycle
    always @(negedge clock) begin
        if (sb.size() > 0) begin
            e = sb.pop_front();
            cmp(e.tag, "cstate",    {28'd0, cstate},    {28'd0, e.cs});
            cmp(e.tag, "phase_end", {31'd0, phase_end}, {31'd0, e.pe});
            cmp(e.tag, "running",   {31'd0, running},   {31'd0, (e.cs != 4'b0000)});
            cmp(e.tag, "bp_hit",    {31'd0, bp_hit},    {31'd0, e.bh});
            cmp(e.tag, "instret",   instret,            e.ir);
        end
    end

    // PC model: advances by 4 on every edge that ends WB
    task automatic cyc();
        logic adv;
        @(negedge clock);
        adv = (cstate == PH_WB) && phase_end;
        @(posedge clock);
        #1;
        if (adv) pc = pc + 32'd4;
    endtask

    task automatic push(input string tag, input logic [3:0] cs, input logic pe);
        sb.push_back('{tag, cs, pe, m_bh, m_ir});
        cyc();
    endtask

    task automatic instr(input string tag);
        push({tag, ".if"}, PH_IF, 1'b1);
        push({tag, ".de"}, PH_DE, 1'b1);
        push({tag, ".ex"}, PH_EX, 1'b1);
        push({tag, ".wb"}, PH_WB, 1'b1);
        m_ir = m_ir + 32'd1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b0; run = 1'b0; step = 1'b0; stop = 1'b0;
        mem_ack = 1'b0; wb_mem = 1'b0; bp_en = 1'b0;
        pc = 32'h38; bp_addr = 32'h40;
        m_ir = 32'd0; m_bh = 1'b0;
        @(posedge clock); #1;

        // reset, then continuous run with zero wait states
        push("rst0", PH_STOP, 1'b0);
        push("rst1", PH_STOP, 1'b0);
        reset = 1'b1; run = 1'b1; mem_ack = 1'b1;
        push("idle", PH_STOP, 1'b0);
        for (int i = 0; i < 3; i++) instr("run");
        run = 1'b0;
        instr("run_last");
        push("run_halt", PH_STOP, 1'b0);

        // single step
        step = 1'b1;
        push("step_req", PH_STOP, 1'b0);
        step = 1'b0;
        instr("step");
        push("step_done", PH_STOP, 1'b0);
        push("step_idle", PH_STOP, 1'b0);

        // wait states: 3 in IF, 2 in WB -> 9 cycles
        step = 1'b1;
        push("ws_req", PH_STOP, 1'b0);
        step = 1'b0; mem_ack = 1'b0;
        for (int i = 0; i < 3; i++) push("ws_if_wait", PH_IF, 1'b0);
        mem_ack = 1'b1;
        push("ws_if", PH_IF, 1'b1);
        push("ws_de", PH_DE, 1'b1);
        push("ws_ex", PH_EX, 1'b1);
        wb_mem = 1'b1; mem_ack = 1'b0;
        for (int i = 0; i < 2; i++) push("ws_wb_wait", PH_WB, 1'b0);
        mem_ack = 1'b1;
        push("ws_wb", PH_WB, 1'b1);
        m_ir = m_ir + 32'd1;
        wb_mem = 1'b0;
        push("ws_done", PH_STOP, 1'b0);

        // breakpoint at 0x40, run from 0x38
        pc = 32'h38; bp_en = 1'b1; run = 1'b1;
        push("bp_go", PH_STOP, 1'b0);
        instr("bp_38");
        instr("bp_3c");
`ifdef PHASE_SEQ_BREAKPOINT_EN
        run = 1'b0;
        push("bp_chk", PH_IF, 1'b0);
        m_bh = 1'b1;
        push("bp_halt", PH_STOP, 1'b0);
        step = 1'b1;
        push("bp_step_req", PH_STOP, 1'b0);
        step = 1'b0;
        m_bh = 1'b0;
        instr("bp_40");
        push("bp_step_done", PH_STOP, 1'b0);
`else
        run = 1'b0;
        instr("bp_40");
        push("bp_none", PH_STOP, 1'b0);
`endif

        // stop during DE completes the instruction, then holds STOP
        run = 1'b1;
        push("sp_go", PH_STOP, 1'b0);
        push("sp_if", PH_IF, 1'b1);
        stop = 1'b1;
        push("sp_de", PH_DE, 1'b1);
        stop = 1'b0;
        push("sp_ex", PH_EX, 1'b1);
        push("sp_wb", PH_WB, 1'b1);
        m_ir = m_ir + 32'd1;
        stop = 1'b1;
        push("sp_halt", PH_STOP, 1'b0);
        run = 1'b0; step = 1'b1;
        push("sp_stepstop", PH_STOP, 1'b0);
        step = 1'b0; stop = 1'b0;
        push("sp_idle", PH_STOP, 1'b0);

        // stop in the same cycle as WB completion
        run = 1'b1;
        push("sw_go", PH_STOP, 1'b0);
        push("sw_if", PH_IF, 1'b1);
        push("sw_de", PH_DE, 1'b1);
        push("sw_ex", PH_EX, 1'b1);
        stop = 1'b1;
        push("sw_wb", PH_WB, 1'b1);
        m_ir = m_ir + 32'd1;
        push("sw_halt", PH_STOP, 1'b0);
        run = 1'b0; stop = 1'b0;
        push("sw_idle", PH_STOP, 1'b0);

        // reset during EX abandons the instruction
        run = 1'b1;
        push("rs_go", PH_STOP, 1'b0);
        push("rs_if", PH_IF, 1'b1);
        push("rs_de", PH_DE, 1'b1);
        reset = 1'b0;
        push("rs_ex", PH_EX, 1'b1);
        reset = 1'b1; run = 1'b0;
        m_ir = 32'd0;
        push("rs_after", PH_STOP, 1'b0);
        push("rs_idle", PH_STOP, 1'b0);

        repeat (2) @(posedge clock);
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending want 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
